// File: rtl/ts_tx_sched.sv
// -----------------------------------------------------------------------------
// ts_tx_sched
//
// Schedules ordered-set transmission for the link training state machine.
// The LTSSM holds os_req high while it wants ordered sets. The scheduler issues
// one-cycle ts_start pulses to ts_gen and waits for ts_done between them.
// SKP ordered sets are inserted every SKP_INTERVAL busy cycles. A watchdog
// catches a ts_gen that never answers.
//
// Ports
//   clk         system clock; everything is on its rising edge
//   rst         synchronous, active-high reset
//   os_req      level request to transmit ordered sets
//   os_type     requested OS: 0=TS1, 1=TS2, 2=EIOS, 3=reserved (sent as TS1)
//   os_tgt      minimum OS count wanted by the LTSSM (0 = no target)
//   ts_info_in  LTSSM state [7:4] / sub-state [3:0] to embed in the OS
//   ts_done     one-cycle pulse from ts_gen on the last symbol of an OS
//   ts_start    one-cycle pulse telling ts_gen to begin one OS
//   ts_type     OS type for ts_gen: 0=TS1, 1=TS2, 2=EIOS, 3=SKP
//   ts_info     latched state/sub-state for ts_gen
//   os_sent     non-SKP ordered sets completed in this run (saturates at 2047)
//   tgt_met     os_tgt != 0 and os_sent >= os_tgt
//   busy        high whenever the scheduler is not idle
//   wdog_err    sticky ts_done timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module ts_tx_sched #(
   parameter int SKP_INTERVAL = 1180,
   parameter int WDOG_MAX     = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        os_req,
   input  logic [1:0]  os_type,
   input  logic [10:0] os_tgt,
   input  logic [7:0]  ts_info_in,
   input  logic        ts_done,
   output logic        ts_start,
   output logic [1:0]  ts_type,
   output logic [7:0]  ts_info,
   output logic [10:0] os_sent,
   output logic        tgt_met,
   output logic        busy,
   output logic        wdog_err
);

   localparam int SKP_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
   localparam int WD_W  = $clog2(WDOG_MAX + 1);
   localparam logic [SKP_W-1:0] SKP_LAST = SKP_W'(SKP_INTERVAL - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WDOG_MAX - 1);
   localparam logic [1:0]       TYPE_SKP = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_SKP_ISSUE
   } state_t;

   state_t             r_state;
   logic               r_ts_start;
   logic [1:0]         r_ts_type;
   logic [1:0]         r_last_type;   // last non-SKP type, survives SKP insertion
   logic [7:0]         r_ts_info;
   logic [10:0]        r_os_sent;
   logic               r_busy;
   logic               r_wdog_err;
   logic [SKP_W-1:0]   r_skp_cnt;
   logic               r_skp_due;
   logic [WD_W-1:0]    r_wdog_cnt;

   logic [1:0]         w_req_type;
   logic               w_skp_wrap;
   logic [10:0]        w_sent_inc;

   // Reserved type 3 goes out as TS1 so that ts_type==3 always means SKP.
   assign w_req_type = (os_type == 2'd3) ? 2'd0 : os_type;
   assign w_skp_wrap = (r_state != S_IDLE) && (r_skp_cnt == SKP_LAST);
   assign w_sent_inc = (r_os_sent == 11'h7FF) ? r_os_sent : r_os_sent + 11'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ts_start  <= 1'b0;
         r_ts_type   <= 2'd0;
         r_last_type <= 2'd0;
         r_ts_info   <= 8'd0;
         r_os_sent   <= 11'd0;
         r_busy      <= 1'b0;
         r_wdog_err  <= 1'b0;
         r_skp_cnt   <= '0;
         r_skp_due   <= 1'b0;
         r_wdog_cnt  <= '0;
      end else begin
         r_ts_start <= 1'b0;

         // SKP interval timer runs in every non-idle state. A wrap while
         // skp_due is already set just leaves it set.
         if (r_state != S_IDLE) begin
            if (w_skp_wrap) begin
               r_skp_cnt <= '0;
               r_skp_due <= 1'b1;
            end else begin
               r_skp_cnt <= r_skp_cnt + SKP_W'(1);
            end
         end

         // Assignments below are placed after the timer so that a return to
         // IDLE discards any pending SKP.
         case (r_state)
            S_IDLE: begin
               if (os_req) begin
                  r_state     <= S_ISSUE;
                  r_ts_start  <= 1'b1;
                  r_busy      <= 1'b1;
                  r_ts_type   <= w_req_type;
                  r_last_type <= w_req_type;
                  r_ts_info   <= ts_info_in;
                  r_os_sent   <= 11'd0;
                  r_skp_cnt   <= '0;
                  r_skp_due   <= 1'b0;
               end
            end

            S_ISSUE, S_SKP_ISSUE: begin
               r_state    <= S_WAIT;
               r_wdog_cnt <= '0;
            end

            S_WAIT: begin
               if (ts_done) begin
                  if (r_ts_type != TYPE_SKP) begin
                     r_os_sent <= w_sent_inc;
                  end
                  if (r_skp_due) begin
                     r_state    <= S_SKP_ISSUE;
                     r_ts_start <= 1'b1;
                     r_ts_type  <= TYPE_SKP;
                     // A wrap in this very cycle must not be lost.
                     if (!w_skp_wrap) begin
                        r_skp_due <= 1'b0;
                     end
                  end else if (os_req) begin
                     r_state     <= S_ISSUE;
                     r_ts_start  <= 1'b1;
                     r_ts_type   <= w_req_type;
                     r_last_type <= w_req_type;
                     r_ts_info   <= ts_info_in;
                     // A new OS type starts a new count.
                     if (w_req_type != r_last_type) begin
                        r_os_sent <= 11'd0;
                     end
                  end else begin
                     r_state   <= S_IDLE;
                     r_busy    <= 1'b0;
                     r_skp_due <= 1'b0;
                  end
               end else if (r_wdog_cnt == WD_LAST) begin
                  r_state    <= S_IDLE;
                  r_busy     <= 1'b0;
                  r_wdog_err <= 1'b1;
                  r_skp_due  <= 1'b0;
               end else begin
                  r_wdog_cnt <= r_wdog_cnt + WD_W'(1);
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // ts_start is gated so that it can never be seen while rst is held.
   assign ts_start = r_ts_start & ~rst;
   assign ts_type  = r_ts_type;
   assign ts_info  = r_ts_info;
   assign os_sent  = r_os_sent;
   assign busy     = r_busy;
   assign wdog_err = r_wdog_err;
   assign tgt_met  = (os_tgt != 11'd0) && (r_os_sent >= os_tgt);

endmodule

// File: tb/tb_ts_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_ts_tx_sched
//
// Scoreboard bench for ts_tx_sched. The stimulus process drives the LTSSM side
// and acts as ts_gen, and it runs a transaction-level reference model. That
// model pushes every expected ts_start (cycle, type, info) into a queue. A
// separate monitor pops the queue whenever the DUT pulses ts_start. SKP
// scheduling is predicted arithmetically from the number of busy cycles since
// the run started.
// -----------------------------------------------------------------------------
module tb_ts_tx_sched;

   localparam int SKP_I = 100;
   localparam int WD    = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        os_req;
   logic [1:0]  os_type;
   logic [10:0] os_tgt;
   logic [7:0]  ts_info_in;
   logic        ts_done;
   logic        ts_start;
   logic [1:0]  ts_type;
   logic [7:0]  ts_info;
   logic [10:0] os_sent;
   logic        tgt_met;
   logic        busy;
   logic        wdog_err;

   ts_tx_sched #(.SKP_INTERVAL(SKP_I), .WDOG_MAX(WD)) dut (
      .clk        (clk),
      .rst        (rst),
      .os_req     (os_req),
      .os_type    (os_type),
      .os_tgt     (os_tgt),
      .ts_info_in (ts_info_in),
      .ts_done    (ts_done),
      .ts_start   (ts_start),
      .ts_type    (ts_type),
      .ts_info    (ts_info),
      .os_sent    (os_sent),
      .tgt_met    (tgt_met),
      .busy       (busy),
      .wdog_err   (wdog_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [1:0] typ;
      logic [7:0] info;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   t       = 0;

   // reference model state
   bit         m_busy = 0;
   bit         m_err = 0;
   bit         m_skp_cur = 0;
   bit         m_rst_chk = 0;
   int         m_run = 0;
   int         m_clear = 0;
   int         m_start = 0;
   int         m_sent = 0;
   logic [1:0] m_type = 2'd0;
   logic [7:0] m_info = 8'd0;

   // ts_gen responder controls
   int done_at = -1;
   int fixed_l = 0;
   bit no_done = 0;
   bit spur_en = 0;
   bit wd_rand = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s cyc=%0d actual=%0d expected=%0d", nm, t, act, exp);
      end
   endtask

   function automatic logic [1:0] map_t(input logic [1:0] x);
      return (x == 2'd3) ? 2'd0 : x;
   endfunction

   // SKP timer wraps seen in busy cycles run_start+1 .. c
   function automatic int nw(input int c);
      return (c - m_run) / SKP_I;
   endfunction

   task automatic push_start(input logic [1:0] ty);
      exp_t e;
      e.cyc  = t + 1;
      e.typ  = ty;
      e.info = m_info;
      sb.push_back(e);
   endtask

   // Decides, from the inputs of cycle t, what the scheduler does next.
   task automatic model();
      logic [1:0] nt;
      if (rst) begin
         m_busy = 0; m_err = 0; m_sent = 0; m_skp_cur = 0;
         m_type = 2'd0; m_info = 8'd0; m_rst_chk = 1; done_at = -1;
      end else if (!m_busy) begin
         if (os_req) begin
            m_busy = 1; m_run = t; m_clear = t + 1; m_start = t + 1;
            m_sent = 0; m_skp_cur = 0;
            m_type = map_t(os_type); m_info = ts_info_in;
            push_start(m_type);
         end
      end else if (t > m_start) begin
         if (ts_done) begin
            if (!m_skp_cur && m_sent < 2047) m_sent++;
            if (nw(t - 1) - nw(m_clear - 1) > 0) begin
               m_skp_cur = 1; m_clear = t; m_start = t + 1;
               push_start(2'd3);
            end else if (os_req) begin
               nt = map_t(os_type);
               if (nt != m_type) m_sent = 0;
               m_type = nt; m_info = ts_info_in; m_skp_cur = 0; m_start = t + 1;
               push_start(m_type);
            end else begin
               m_busy = 0;
            end
         end else if (t - m_start == WD) begin
            m_err = 1; m_busy = 0;
         end
      end
   endtask

   // One clock cycle: the inputs for cycle t are already applied.
   task automatic step();
      if (rst) begin
         while (sb.size() > 0 && sb[sb.size()-1].cyc >= t) sb.delete(sb.size()-1);
      end
      @(negedge clk);
      if (m_rst_chk) begin
         chk("rst_ts_type", 32'(ts_type), 32'd0);
         chk("rst_ts_info", 32'(ts_info), 32'd0);
         m_rst_chk = 0;
      end
      chk("busy", 32'(busy), 32'(m_busy));
      chk("os_sent", 32'(os_sent), 32'(m_sent));
      chk("wdog_err", 32'(wdog_err), 32'(m_err));
      chk("tgt_met", 32'(tgt_met), (os_tgt != 0 && m_sent >= int'(os_tgt)) ? 32'd1 : 32'd0);
      if (ts_start === 1'b1) begin
         if (no_done) done_at = -1;
         else if (fixed_l > 0) done_at = t + fixed_l;
         else if (wd_rand && $urandom_range(0, 59) == 0) done_at = -1;
         else done_at = t + int'($urandom_range(1, 20));
      end
      model();
      @(posedge clk);
      #1;
      t++;
      ts_done = (t == done_at) || (spur_en && $urandom_range(0, 199) == 0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (ts_start === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL unexpected_start cyc=%0d actual=1 expected=0", t);
         end else begin
            e = sb.pop_front();
            $display("[TB] OS start cyc=%0d type=%0d info=%02h os_sent=%0d", t, ts_type, ts_info, os_sent);
            chk("start_cyc", 32'(t), 32'(e.cyc));
            chk("start_type", 32'(ts_type), 32'(e.typ));
            chk("start_info", 32'(ts_info), 32'(e.info));
         end
      end else if (sb.size() > 0 && sb[0].cyc <= t) begin
         e = sb.pop_front();
         n_tests++; n_fail++;
         $display("[TB] FAIL missing_start cyc=%0d actual=0 expected=1 (type %0d)", t, e.typ);
      end
   end

   initial begin
      rst = 1'b1; os_req = 1'b0; os_type = 2'd0; os_tgt = 11'd0;
      ts_info_in = 8'h00; ts_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_rst_chk = 1;
      repeat (3) step();
      rst = 1'b0;
      repeat (3) step();

      // 16 TS1 with ts_done every 16 cycles, target 16
      os_req = 1; os_type = 2'd0; os_tgt = 11'd16; ts_info_in = 8'h21; fixed_l = 16;
      for (int i = 0; i < 600 && m_sent < 16; i++) step();
      repeat (3) step();
      os_req = 0;
      for (int i = 0; i < 100 && m_busy; i++) step();
      repeat (3) step();

      // type switch after 8 TS1
      os_req = 1; os_type = 2'd0; os_tgt = 11'd0; ts_info_in = 8'h32; fixed_l = 4;
      for (int i = 0; i < 300 && m_sent < 8; i++) step();
      os_type = 2'd1; ts_info_in = 8'h33;
      repeat (40) step();
      os_req = 0;
      repeat (60) step();

      // randomized traffic
      fixed_l = 0; spur_en = 1; wd_rand = 1;
      for (int i = 0; i < 6000; i++) begin
         rst = ($urandom_range(0, 1499) == 0);
         if (!os_req) os_req = ($urandom_range(0, 7) == 0);
         else if ($urandom_range(0, 149) == 0) os_req = 0;
         if ($urandom_range(0, 199) == 0) os_type = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0) ts_info_in = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 299) == 0) os_tgt = 11'($urandom_range(0, 20));
         step();
      end
      rst = 0; os_req = 0; spur_en = 0; wd_rand = 0; fixed_l = 3;
      repeat (120) step();

      // watchdog: ts_done withheld
      rst = 1; step(); rst = 0;
      os_req = 1; os_type = 2'd2; ts_info_in = 8'h44; no_done = 1;
      for (int i = 0; i < 300 && !m_err; i++) step();
      chk("wdog_fired", 32'(wdog_err), 32'd1);
      os_req = 0;
      repeat (120) step();
      chk("wdog_sticky", 32'(wdog_err), 32'd1);
      no_done = 0;
      rst = 1; step(); rst = 0;
      step();

      // reset while in WAIT with a SKP pending
      os_req = 1; os_type = 2'd0; ts_info_in = 8'h55; fixed_l = 30;
      for (int i = 0; i < 600; i++) begin
         if (m_busy && t > m_start && nw(t - 1) - nw(m_clear - 1) > 0) break;
         step();
      end
      rst = 1; step(); rst = 0;
      os_type = 2'd1; ts_info_in = 8'h56; fixed_l = 5;
      repeat (10) step();
      os_req = 0;
      repeat (40) step();

      // os_sent saturation
      os_req = 1; os_type = 2'd2; os_tgt = 11'd2047; ts_info_in = 8'h66; fixed_l = 1;
      repeat (4600) step();
      chk("sent_saturated", 32'(os_sent), 32'd2047);
      os_req = 0; fixed_l = 3;
      repeat (60) step();

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ts_tx_sched.md
TS_TX_SCHED -- requirements
Module: ts_tx_sched

Interface
REQ-001 Parameter SKP_INTERVAL, default 1180, SHALL set the cycles between SKP ordered sets while the scheduler is active.
REQ-002 Parameter WDOG_MAX, default 64, SHALL set the maximum cycles to wait for ts_done before a timeout.
REQ-003 clk  input  1  SHALL be the 1 GHz system clock; all logic is on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 os_req  input  1  SHALL be a level request from the LTSSM to transmit ordered sets.
REQ-006 os_type  input  2  SHALL select the ordered set: 0=TS1, 1=TS2, 2=EIOS, 3=reserved (treated as TS1).
REQ-007 os_tgt  input  11  SHALL give the minimum OS count; 0 means no target.
REQ-008 ts_info_in  input  8  SHALL carry the LTSSM state in [7:4] and the sub-state in [3:0].
REQ-009 ts_done  input  1  SHALL be a one-cycle pulse from ts_gen marking the last symbol of the current OS.
REQ-010 ts_start  output  1  SHALL be a one-cycle pulse telling ts_gen to begin one OS.
REQ-011 ts_type  output  2  SHALL give the OS type for ts_gen: 0=TS1, 1=TS2, 2=EIOS, 3=SKP.
REQ-012 ts_info  output  8  SHALL give the latched state/sub-state for ts_gen.
REQ-013 os_sent  output  11  SHALL count non-SKP ordered sets completed in the current run.
REQ-014 tgt_met  output  1  SHALL assert when os_tgt != 0 and os_sent >= os_tgt.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.
REQ-016 wdog_err  output  1  SHALL be a sticky flag set on a ts_done timeout.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and SKP_ISSUE.
REQ-018 IDLE with os_req=1 in cycle N SHALL move to ISSUE, latching os_type to ts_type and ts_info_in to ts_info, and clearing os_sent, the SKP timer and skp_due.
REQ-019 ISSUE and SKP_ISSUE SHALL assert ts_start for exactly one cycle (cycle N+1 from REQ-018) and then go to WAIT.
REQ-020 SKP_ISSUE SHALL drive ts_type=3 and leave ts_info unchanged.
REQ-021 In WAIT, ts_start SHALL be 0; on ts_done after a non-SKP OS, os_sent SHALL increment, saturating at 2047; after a SKP OS it SHALL hold.
REQ-022 On ts_done the next state SHALL be chosen in this priority order: skp_due=1 goes to SKP_ISSUE; else os_req=1 goes to ISSUE and relatches os_type/ts_info_in; else IDLE.
REQ-023 There SHALL be zero idle cycles between ordered sets: ts_start is asserted in the cycle after ts_done.
REQ-024 If the relatched os_type differs from the previous non-SKP type, os_sent SHALL clear to 0 in that same cycle.
REQ-025 If os_req drops mid-OS, the current OS SHALL complete; os_req is sampled only at ts_done.
REQ-026 The SKP timer SHALL count every cycle while busy=1.
REQ-027 When the SKP timer reaches SKP_INTERVAL-1, it SHALL wrap to 0 and set skp_due.
REQ-028 skp_due SHALL clear on entry to SKP_ISSUE; if it sets again while already set, there SHALL be no double count.
REQ-029 If skp_due is still set when the FSM returns to IDLE, it SHALL be discarded.
REQ-030 A ts_done received in IDLE, ISSUE or SKP_ISSUE SHALL be ignored.
REQ-031 The watchdog SHALL count cycles in WAIT and reset on entry to WAIT.
REQ-032 When the watchdog reaches WDOG_MAX without ts_done, the block SHALL set wdog_err and go to IDLE.
REQ-033 wdog_err SHALL clear only on rst.
REQ-034 tgt_met SHALL be a combinational function of os_sent and os_tgt.
REQ-035 tgt_met SHALL NOT stop transmission; the LTSSM ends a run by dropping os_req.

Reset
REQ-036 When rst=1 at a clock edge, the block SHALL enter IDLE from any state, including mid-OS.
REQ-037 Reset SHALL set ts_start=0, ts_type=0, ts_info=0, os_sent=0, busy=0 and wdog_err=0.
REQ-038 Reset SHALL clear the SKP timer, skp_due and the watchdog.
REQ-039 While rst=1, ts_start SHALL NOT assert.

Verification
REQ-040 os_req=1, os_type=0, os_tgt=16, ts_done every 16 cycles -> ts_start first at N+1, os_sent reaches 16, and tgt_met rises in the cycle after the 16th ts_done.
REQ-041 os_type switches 0->1 after 8 TS1 -> the next ts_start carries ts_type=1 and os_sent restarts at 0 then 1.
REQ-042 SKP_INTERVAL=100, continuous requests -> one ts_type=3 OS after the first ts_done following cycle 99, and os_sent is not incremented by it.
REQ-043 os_req dropped 3 cycles into an OS -> no further ts_start after that ts_done, and busy=0 the next cycle.
REQ-044 ts_done withheld -> wdog_err=1 and busy=0 after WDOG_MAX cycles in WAIT, and wdog_err holds until rst.
REQ-045 rst asserted in WAIT with skp_due=1 -> all outputs reach reset values the next cycle, and the next os_req produces a TS (not SKP) ts_start.
